// File: rtl/rf_pkg.sv
// Shared constants and types for the multiport register file.
// Behaviour switch: define RF_BYPASS_EN to enable write-first forwarding.
package rf_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int RF_NRD    = 2;

  localparam int                   RF_GP_IDX  = 28;
  localparam logic [RF_DATA_W-1:0] RF_GP_INIT = 32'h0000_1800;
  localparam int                   RF_SP_IDX  = 29;
  localparam logic [RF_DATA_W-1:0] RF_SP_INIT = 32'h0000_2ffc;

  typedef logic [RF_ADDR_W-1:0] reg_idx_t;

  function automatic int nregs(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/rf_multiport_if.sv
// Write, read and scoreboard signals between the pipeline and the register file.
// RF_BYPASS_EN changes only the timing of rd_data/rd_busy, not this port list.
interface rf_multiport_if
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NRD    = RF_NRD
);
  localparam int NREGS = nregs(ADDR_W);

  logic                  wr0_en;
  logic [ADDR_W-1:0]     wr0_reg;
  logic [DATA_W-1:0]     wr0_data;
  logic                  wr1_en;
  logic [ADDR_W-1:0]     wr1_reg;
  logic [DATA_W-1:0]     wr1_data;
  logic [NRD*ADDR_W-1:0] rd_reg;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic                  sb_set;
  logic [ADDR_W-1:0]     sb_reg;
  logic [NREGS-1:0]      busy_vec;

  modport master (
    output wr0_en, wr0_reg, wr0_data,
    output wr1_en, wr1_reg, wr1_data,
    output rd_reg, sb_set, sb_reg,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  wr0_en, wr0_reg, wr0_data,
    input  wr1_en, wr1_reg, wr1_data,
    input  rd_reg, sb_set, sb_reg,
    output rd_data, rd_busy, busy_vec
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy flags: sb_set marks a pending producer, a write retires it.
// With RF_BYPASS_EN, a same-cycle write hides the busy bit on the read lookup.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NRD    = RF_NRD
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sb_set,
  input  logic [ADDR_W-1:0]     sb_reg,
  input  logic                  wr0_en,
  input  logic [ADDR_W-1:0]     wr0_reg,
  input  logic                  wr1_en,
  input  logic [ADDR_W-1:0]     wr1_reg,
  input  logic [NRD*ADDR_W-1:0] rd_reg,
  output logic [NRD-1:0]        rd_busy,
  output logic [(1<<ADDR_W)-1:0] busy_vec
);
  localparam int NREGS = nregs(ADDR_W);

  logic [NREGS-1:0] busy_reg;
  logic [NREGS-1:0] busy_next;

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_bit
      if (gi == 0) begin : g_zero
        assign busy_next[gi] = 1'b0;
      end else begin : g_gpr
        localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
        logic set_hit, clr_hit;
        assign set_hit = sb_set && (sb_reg == IDX);
        assign clr_hit = (wr0_en && (wr0_reg == IDX)) || (wr1_en && (wr1_reg == IDX));
        // A new producer issued in the same cycle outranks the retiring write.
        assign busy_next[gi] = set_hit | (busy_reg[gi] & ~clr_hit);
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) busy_reg <= '0;
    else     busy_reg <= busy_next;
  end

  assign busy_vec = busy_reg;

  generate
    for (gi = 0; gi < NRD; gi++) begin : g_lookup
      logic [ADDR_W-1:0] idx;
      assign idx = rd_reg[gi*ADDR_W +: ADDR_W];
`ifdef RF_BYPASS_EN
      logic wr_hit, sb_hit;
      assign wr_hit = (idx != '0) &&
                      ((wr0_en && (wr0_reg == idx)) || (wr1_en && (wr1_reg == idx)));
      assign sb_hit = sb_set && (sb_reg == idx);
      assign rd_busy[gi] = busy_reg[idx] & ~(wr_hit & ~sb_hit);
`else
      assign rd_busy[gi] = busy_reg[idx];
`endif
    end
  endgenerate

endmodule

// File: rtl/rf_multiport.sv
// MIPS general-purpose register file: two write ports, NRD async read ports, busy scoreboard.
// Define RF_BYPASS_EN for write-first forwarding of same-cycle writes to the read ports.
module rf_multiport
  import rf_pkg::*;
#(
  parameter int                DATA_W  = RF_DATA_W,
  parameter int                ADDR_W  = RF_ADDR_W,
  parameter int                NRD     = RF_NRD,
  parameter int                GP_IDX  = RF_GP_IDX,
  parameter logic [DATA_W-1:0] GP_INIT = DATA_W'(RF_GP_INIT),
  parameter int                SP_IDX  = RF_SP_IDX,
  parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(RF_SP_INIT)
)(
  input logic           clk,
  input logic           rst,
  rf_multiport_if.slave bus
);
  localparam int NREGS = nregs(ADDR_W);

  logic [DATA_W-1:0] regs_reg  [NREGS];
  logic [DATA_W-1:0] regs_next [NREGS];
  logic [DATA_W-1:0] rst_val   [NREGS];

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign rst_val[gi]   = '0;
        assign regs_next[gi] = '0;
      end else begin : g_gpr
        localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
        assign rst_val[gi] = (gi == GP_IDX) ? GP_INIT :
                             (gi == SP_IDX) ? SP_INIT : '0;
        // Port 1 (load return) takes priority on a same-index collision.
        assign regs_next[gi] = (bus.wr1_en && (bus.wr1_reg == IDX)) ? bus.wr1_data :
                               (bus.wr0_en && (bus.wr0_reg == IDX)) ? bus.wr0_data :
                               regs_reg[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_reg[i] <= rst_val[i];
    end else begin
      for (int i = 0; i < NREGS; i++) regs_reg[i] <= regs_next[i];
    end
  end

  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [ADDR_W-1:0] idx;
      assign idx = bus.rd_reg[gi*ADDR_W +: ADDR_W];
`ifdef RF_BYPASS_EN
      logic hit0, hit1;
      assign hit0 = bus.wr0_en && (bus.wr0_reg == idx) && (idx != '0);
      assign hit1 = bus.wr1_en && (bus.wr1_reg == idx) && (idx != '0);
      assign bus.rd_data[gi*DATA_W +: DATA_W] = hit1 ? bus.wr1_data :
                                                hit0 ? bus.wr0_data :
                                                regs_reg[idx];
`else
      assign bus.rd_data[gi*DATA_W +: DATA_W] = regs_reg[idx];
`endif
    end
  endgenerate

  rf_scoreboard #(
    .ADDR_W (ADDR_W),
    .NRD    (NRD)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .sb_set   (bus.sb_set),
    .sb_reg   (bus.sb_reg),
    .wr0_en   (bus.wr0_en),
    .wr0_reg  (bus.wr0_reg),
    .wr1_en   (bus.wr1_en),
    .wr1_reg  (bus.wr1_reg),
    .rd_reg   (bus.rd_reg),
    .rd_busy  (bus.rd_busy),
    .busy_vec (bus.busy_vec)
  );

endmodule

// File: doc/rf_multiport.md
# rf_multiport

Parametrised general-purpose register file for the pipelined MIPS core. It provides a configurable number of asynchronous read ports and two write ports (ALU/writeback and load return). It also carries an integrated per-register busy scoreboard that the issue stage uses to stall on pending producers. Register 0 is hardwired to zero, and the global and stack pointers come out of reset at fixed parameter values.

## Interface
Clock is `clk`; reset is `rst`, synchronous and active-high.

Parameters:
- `DATA_W`, 32, register width
- `ADDR_W`, 5, register index width; register count `NREGS = 2**ADDR_W`
- `NRD`, 2, number of read ports (1–4)
- `GP_IDX`, 28, index loaded with `GP_INIT` at reset
- `GP_INIT`, 32'h0000_1800, reset value of `GP_IDX`
- `SP_IDX`, 29, index loaded with `SP_INIT` at reset
- `SP_INIT`, 32'h0000_2ffc, reset value of `SP_IDX`

Ports:
- `clk`  in  1  clock; all state updates on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `wr0_en`  in  1  write port 0 enable
- `wr0_reg`  in  ADDR_W  write port 0 index
- `wr0_data`  in  DATA_W  write port 0 data
- `wr1_en`  in  1  write port 1 enable
- `wr1_reg`  in  ADDR_W  write port 1 index
- `wr1_data`  in  DATA_W  write port 1 data
- `rd_reg`  in  NRD*ADDR_W  packed read indices; port k uses bits [k*ADDR_W +: ADDR_W]
- `rd_data`  out  NRD*DATA_W  packed read data
- `rd_busy`  out  NRD  scoreboard busy bit of each read index
- `sb_set`  in  1  issue stage marks `sb_reg` as having a pending write
- `sb_reg`  in  ADDR_W  index to mark busy
- `busy_vec`  out  NREGS  full scoreboard state

## Operation
- Storage: NREGS × DATA_W flops; writes take effect at the rising edge.
- Reset (`rst`=1 at the edge): all registers go to 0, except `GP_IDX`=GP_INIT and `SP_IDX`=SP_INIT. `busy_vec` clears to all-zero. Reset overrides every write and `sb_set` in the same cycle.
- Register 0:
  - writes to it are discarded;
  - reads of it always return 0 with `rd_busy`=0;
  - `sb_set` on it is ignored.
- Write conflict: if both ports are enabled to the same index, port 1 wins.
- Read: combinational from the `rd_reg` index; each port is independent; ports may alias.
- Scoreboard:
  - a bit is set by `sb_set`;
  - a bit is cleared by any enabled write to that index;
  - if a set and a clear hit the same index in the same cycle, the set wins (a new producer has been issued).
  - `rd_busy[k]` = `busy_vec[rd_reg[k]]`, combinational from the registered state.

## Timing
- Read latency is 0 cycles (combinational).
- Write-to-read latency:
  - 1 cycle without bypass;
  - 0 cycles with bypass enabled (see Configuration).
- `sb_set` at edge N: `busy_vec` reflects it from N+1.
- A write at edge N clears busy from N+1, or combinationally in the same cycle when bypass is enabled.
- Outputs during and immediately after reset:
  - `rd_data` shows the reset contents;
  - `rd_busy`=0 and `busy_vec`=0.

## Configuration
- `RF_BYPASS_EN` defined: write-first forwarding.
  - A read whose index matches an enabled, non-zero write index in the same cycle returns that write's data; port 1 wins over port 0.
  - `rd_busy` for that index reads 0 that cycle, unless `sb_set` targets the same index.
- `RF_BYPASS_EN` undefined: read data and busy bits come purely from stored state; a same-cycle write is visible from the next cycle.

## Structure
- Package `rf_pkg`: default DATA_W/ADDR_W, GP/SP index and init constants, and `reg_idx_t` for the index type.
- Sub-module `rf_scoreboard`:
  - owns the NREGS busy flops and the set/clear priority;
  - provides a combinational lookup per read port;
  - takes the write enables and indices as clear inputs.
- Top level contains the storage array, write arbitration, read muxing and the optional bypass.

## Test plan
- Reset, then read r28, r29, r5 → 0x1800, 0x2ffc, 0; `busy_vec`=0.
- Write r0=0xDEAD via wr0, next cycle read r0 → 0; `sb_set` r0 → `busy_vec[0]` stays 0.
- Same cycle: wr0 r7=0x11 and wr1 r7=0x22 → r7 reads 0x22 next cycle.
- Read r9 while wr1 writes r9=0xABCD:
  - with `RF_BYPASS_EN` → 0xABCD the same cycle;
  - without → old value, then 0xABCD the next cycle.
- `sb_set` r12, then wr0 r12 two cycles later → `rd_busy`=1 for the two intervening cycles, 0 after the write edge. Repeat with `sb_set` r12 and a write to r12 in the same cycle → busy stays 1.
- Assert `rst` while writes and `sb_set` are active mid-sequence → all registers at reset values and `busy_vec`=0 on the next cycle.
